// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with a 2-bit IR and three DR chains.
// The chains are boundary scan, internal scan and a 1-bit bypass register.
module jtag_tap_ctrl (
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       TDO_BSR,
  input  logic       TDO_ISR,
  output logic [1:0] inst,
  output logic       clockdr_bs,
  output logic       shiftdr_bs,
  output logic       updatedr_bs,
  output logic       clockdr_is,
  output logic       shiftdr_is,
  output logic       updatedr_is,
  output logic       TDO,
  output logic [3:0] tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state_q, state_d;
  logic [1:0] inst_q, inst_d;
  logic [1:0] ir_q, ir_d;
  logic       byp_q, byp_d;
  logic       sel_bsr, sel_isr, sel_byp;

  always_ff @(posedge TCLK) begin
    if (TRST) begin
      state_q <= TLR;
      inst_q  <= 2'b01;
      ir_q    <= 2'b01;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ir_q    <= ir_d;
      byp_q   <= byp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // The chain select comes from the registered inst, so an IR update steers from the next cycle.
  assign sel_isr = (inst_q == 2'b10);
  assign sel_byp = (inst_q == 2'b01);
  assign sel_bsr = !sel_isr && !sel_byp;

  always_comb begin
    inst_d = inst_q;
    ir_d   = ir_q;
    byp_d  = byp_q;
    case (state_q)
      CAP_IR:  ir_d   = 2'b01;
      SH_IR:   ir_d   = {TDI, ir_q[1]};
      UPD_IR:  inst_d = ir_q;
      CAP_DR:  if (sel_byp) byp_d = 1'b0;
      SH_DR:   if (sel_byp) byp_d = TDI;
      default: ;
    endcase
    // Loading the defaults on entry keeps inst at BYPASS for every cycle spent in TLR.
    if (state_d == TLR) begin
      inst_d = 2'b01;
      ir_d   = 2'b01;
      byp_d  = 1'b0;
    end
  end

  assign clockdr_bs  = sel_bsr && ((state_q == CAP_DR) || (state_q == SH_DR));
  assign shiftdr_bs  = sel_bsr && (state_q == SH_DR);
  assign updatedr_bs = sel_bsr && (state_q == UPD_DR);
  assign clockdr_is  = sel_isr && ((state_q == CAP_DR) || (state_q == SH_DR));
  assign shiftdr_is  = sel_isr && (state_q == SH_DR);
  assign updatedr_is = sel_isr && (state_q == UPD_DR);

  always_comb begin
    TDO = 1'b0;
    if (state_q == SH_IR) begin
      TDO = ir_q[0];
    end else if (state_q == SH_DR) begin
      if (sel_isr)      TDO = TDO_ISR;
      else if (sel_byp) TDO = byp_q;
      else              TDO = TDO_BSR;
    end
  end

  assign inst      = inst_q;
  assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: a table-driven TAP model checked every cycle,
// plus directed scans with hand-computed expectations.
module tb_jtag_tap_ctrl;

  logic       TCLK = 1'b0;
  logic       TRST = 1'b1;
  logic       TMS = 1'b0, TDI = 1'b0, TDO_BSR = 1'b0, TDO_ISR = 1'b0;
  logic [1:0] inst;
  logic       clockdr_bs, shiftdr_bs, updatedr_bs;
  logic       clockdr_is, shiftdr_is, updatedr_is;
  logic       TDO;
  logic [3:0] tap_state;

  jtag_tap_ctrl dut (
    .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR), .inst(inst),
    .clockdr_bs(clockdr_bs), .shiftdr_bs(shiftdr_bs), .updatedr_bs(updatedr_bs),
    .clockdr_is(clockdr_is), .shiftdr_is(shiftdr_is), .updatedr_is(updatedr_is),
    .TDO(TDO), .tap_state(tap_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 TCLK = ~TCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  // Observation vector: {state[12:9], inst[8:7], cbs, sbs, ubs, cis, sis, uis, tdo}
  logic [5:0]  dut_str;
  logic [12:0] dut_obs;
  assign dut_str = {clockdr_bs, shiftdr_bs, updatedr_bs, clockdr_is, shiftdr_is, updatedr_is};
  assign dut_obs = {tap_state, inst, dut_str, TDO};

  function automatic logic [12:0] obs(input logic [3:0] st, input logic [1:0] in,
                                      input logic [5:0] str, input logic tdo);
    return {st, in, str, tdo};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic hand(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_state;
  logic [1:0] m_inst, m_ir;
  logic       m_byp;
  bit         m_valid = 0;
  logic [12:0] exp_q[$];

  task automatic rule(input logic [3:0] from, input logic [3:0] on0, input logic [3:0] on1);
    nxt0[from] = on0;
    nxt1[from] = on1;
  endtask

  initial begin
    rule(4'hF, 4'hC, 4'hF); rule(4'hC, 4'hC, 4'h7);
    rule(4'h7, 4'h6, 4'h4); rule(4'h4, 4'hE, 4'hF);
    rule(4'h6, 4'h2, 4'h1); rule(4'hE, 4'hA, 4'h9);
    rule(4'h2, 4'h2, 4'h1); rule(4'hA, 4'hA, 4'h9);
    rule(4'h1, 4'h3, 4'h5); rule(4'h9, 4'hB, 4'hD);
    rule(4'h3, 4'h3, 4'h0); rule(4'hB, 4'hB, 4'h8);
    rule(4'h0, 4'h2, 4'h5); rule(4'h8, 4'hA, 4'hD);
    rule(4'h5, 4'hC, 4'h7); rule(4'hD, 4'hC, 4'h7);
  end

  // 0 = boundary chain, 1 = internal chain, 2 = bypass bit
  function automatic int chain_of(input logic [1:0] in);
    if (in == 2'b10) return 1;
    if (in == 2'b01) return 2;
    return 0;
  endfunction

  function automatic logic [12:0] model_obs();
    int   ch;
    logic cap, sh, upd, tdo;
    logic [5:0] str;
    ch  = chain_of(m_inst);
    cap = (m_state == 4'h6);
    sh  = (m_state == 4'h2);
    upd = (m_state == 4'h5);
    str = 6'b0;
    if (ch == 0) str[5:3] = {cap | sh, sh, upd};
    if (ch == 1) str[2:0] = {cap | sh, sh, upd};
    tdo = 1'b0;
    if (m_state == 4'hA) tdo = m_ir[0];
    if (sh) tdo = (ch == 0) ? TDO_BSR : (ch == 1) ? TDO_ISR : m_byp;
    return {m_state, m_inst, str, tdo};
  endfunction

  initial forever begin
    logic [3:0] was;
    @(posedge TCLK);
    if (TRST) begin
      m_state = 4'hF; m_inst = 2'b01; m_ir = 2'b01; m_byp = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      was     = m_state;
      m_state = TMS ? nxt1[was] : nxt0[was];
      if (was == 4'hE) m_ir = 2'b01;
      if (was == 4'hA) m_ir = {TDI, m_ir[1]};
      if (was == 4'hD) m_inst = m_ir;
      if (chain_of(m_inst) == 2 && was == 4'h6) m_byp = 1'b0;
      if (chain_of(m_inst) == 2 && was == 4'h2) m_byp = TDI;
      if (m_state == 4'hF) begin
        m_inst = 2'b01; m_ir = 2'b01; m_byp = 1'b0;
      end
    end
    if (m_valid) exp_q.push_back(model_obs());
  end

  // ---------------- scoreboard compare ----------------
  initial forever begin
    logic [12:0] e;
    @(negedge TCLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_obs !== e) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t: got %h required %h", $time, dut_obs, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  int cnt [6];

  task automatic clr_cnt();
    for (int i = 0; i < 6; i++) cnt[i] = 0;
  endtask

  function automatic logic [23:0] cnt_vec();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[23-4*i -: 4] = cnt[i][3:0];
    return v;
  endfunction

  task automatic step(input logic tms, input logic tdi, input logic bsr = 1'b0,
                      input logic isr = 1'b0, input logic trst = 1'b0);
    @(negedge TCLK); #1;
    TMS = tms; TDI = tdi; TDO_BSR = bsr; TDO_ISR = isr; TRST = trst;
    @(posedge TCLK); #1;
    for (int i = 0; i < 6; i++) cnt[i] += int'(dut_str[5-i]);
  endtask

  // From RTI: capture IR, shift v[0] then v[1], update, back to RTI.
  task automatic load_ir(input logic [1:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    hand("ir_shift1_tdo", {tap_state, TDO}, {4'hA, 1'b1});
    step(0, v[0]);
    hand("ir_shift2_tdo", {tap_state, TDO}, {4'hA, 1'b0});
    step(1, v[1]); step(1, 0); step(0, 0);
    hand("ir_loaded", {tap_state, inst}, {4'hC, v});
  endtask

  // From RTI: capture DR, three shift cycles, exit, update, back to RTI.
  task automatic dr_scan(input string tag, input logic [2:0] tdi_p, input logic [2:0] bsr_p,
                         input logic [2:0] isr_p, input logic [2:0] exp_tdo,
                         input logic [23:0] exp_cnt);
    clr_cnt();
    step(1, 0); step(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 0) ? 1'b0 : tdi_p[i-1], bsr_p[i], isr_p[i]);
      hand({tag, "_shift_tdo"}, {tap_state, TDO}, {4'h2, exp_tdo[i]});
    end
    step(1, tdi_p[2]); step(1, 0); step(0, 0);
    hand({tag, "_strobe_counts"}, cnt_vec(), exp_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge TCLK); #1;
    hand("reset_obs", dut_obs, obs(4'hF, 2'b01, 6'b0, 1'b0));
    step(0, 0);
    hand("after_reset_rti", dut_obs, obs(4'hC, 2'b01, 6'b0, 1'b0));

    load_ir(2'b00);
    dr_scan("extest", 3'b000, 3'b101, 3'b010, 3'b101, 24'h431000);
    load_ir(2'b10);
    dr_scan("intscan", 3'b000, 3'b100, 3'b011, 3'b011, 24'h000431);
    load_ir(2'b01);
    dr_scan("bypass", 3'b101, 3'b111, 3'b111, 3'b010, 24'h000000);

    // Bypass bit must survive a pause.
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 1); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    hand("bypass_after_pause", {tap_state, TDO}, {4'h2, 1'b1});
    step(1, 0); step(1, 0); step(0, 0);

    // IR contents must survive a pause.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(1, 1); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    hand("ir_after_pause", {tap_state, TDO}, {4'hA, 1'b0});
    step(1, 0); step(1, 0); step(0, 0);
    hand("ir_pause_inst", {tap_state, inst}, {4'hC, 2'b01});

    // Five TMS=1 edges from SH_DR land in TLR with inst forced to BYPASS.
    load_ir(2'b11);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    hand("five_tms_tlr", dut_obs, obs(4'hF, 2'b01, 6'b0, 1'b0));
    step(0, 0);

    // Pause mid-shift with INTSCAN, then abort with TRST.
    load_ir(2'b10);
    clr_cnt();
    step(1, 0); step(0, 0); step(0, 1);
    step(1, 1); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    hand("intscan_resume", dut_obs, obs(4'h2, 2'b10, 6'b000110, 1'b0));
    step(0, 0, 0, 0, 1);
    hand("trst_abort", dut_obs, obs(4'hF, 2'b01, 6'b0, 1'b0));
    hand("abort_no_update", cnt_vec(), 24'h000320);
    step(0, 0);
    step(0, 0);

    @(negedge TCLK); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-002 TCLK  input  1  test clock; all state changes on the rising edge.
REQ-003 TRST  input  1  synchronous active-high reset.
REQ-004 TMS  input  1  test mode select; sampled on the rising TCLK edge.
REQ-005 TDI  input  1  serial test data in.
REQ-006 TDO_BSR  input  1  serial out of the boundary scan chain.
REQ-007 TDO_ISR  input  1  serial out of the internal scan chain.
REQ-008 inst  output  2  active instruction: 00 EXTEST, 01 BYPASS, 10 INTSCAN, 11 SIGSEL.
REQ-009 clockdr_bs, shiftdr_bs, updatedr_bs  output  1 each  boundary-chain strobes.
REQ-010 clockdr_is, shiftdr_is, updatedr_is  output  1 each  internal-chain strobes.
REQ-011 TDO  output  1  serial test data out.
REQ-012 tap_state  output  4  current TAP state code, for observability.

Function
REQ-013 The block SHALL implement the 16-state TAP FSM with these codes: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.
REQ-014 Transitions (TMS=0 / TMS=1) SHALL be:
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- SEL_IR: CAP_IR / TLR
- CAP_x: SH_x / EX1_x
- SH_x: SH_x / EX1_x
- EX1_x: PAU_x / UPD_x
- PAU_x: PAU_x / EX2_x
- EX2_x: SH_x / UPD_x
- UPD_x: RTI / SEL_DR
REQ-015 Five consecutive TCLK edges with TMS=1 SHALL reach TLR from any state.
REQ-016 The DR chain SHALL be selected from inst: 00 and 11 select the BSR, 10 selects the ISR, 01 selects a 1-bit bypass register.
REQ-017 clockdr_bs SHALL be 1 iff state is CAP_DR or SH_DR and the BSR is selected; clockdr_is SHALL follow the same rule for the ISR.
REQ-018 shiftdr_* SHALL be 1 iff state is SH_DR and that chain is selected.
REQ-019 updatedr_* SHALL be 1 iff state is UPD_DR and that chain is selected; it is therefore a one-cycle pulse per UPD_DR visit.
REQ-020 All strobes SHALL be pure decodes of the state register and inst, so they are valid in the same cycle as tap_state, with no extra latency.
REQ-021 When the bypass chain is selected, all six strobes SHALL stay 0.
REQ-022 The IR shift register ir_sr[1:0] SHALL behave as follows:
- CAP_IR edge loads 2'b01.
- Each SH_IR edge does ir_sr <= {TDI, ir_sr[1]}.
- The UPD_IR edge copies ir_sr to inst.
- inst SHALL change only on UPD_IR edges, TLR, or reset.
REQ-023 The bypass register SHALL load 0 on a CAP_DR edge and load TDI on each SH_DR edge, when bypass is selected.
REQ-024 TDO SHALL be:
- ir_sr[0] in SH_IR;
- in SH_DR, TDO_BSR, TDO_ISR or the bypass bit, according to REQ-016;
- 0 in all other states.
REQ-025 A change of inst at UPD_IR SHALL affect strobe and TDO selection from the next cycle only.
REQ-026 Pausing (PAU_x) and re-entering SH_x via EX2_x SHALL preserve ir_sr and the bypass bit unchanged.
REQ-027 Every cycle the FSM spends in TLR SHALL force inst=01, ir_sr=01 and bypass=0.

Reset
REQ-028 While TRST=1 at a TCLK edge, the block SHALL go to state TLR with inst=01, ir_sr=01 and bypass=0, regardless of TMS.
REQ-029 After reset, all six strobes and TDO SHALL read 0 and tap_state SHALL read F.
REQ-030 TRST asserted mid-shift (SH_DR or SH_IR) SHALL abort the shift with no update pulse, and inst SHALL become 01.
REQ-031 Reset SHALL have priority over TMS and over all register updates in the same cycle.

Verification
REQ-032 TRST=1 for 1 cycle, then TMS=0 -> tap_state F then C; inst=01; all strobes 0.
REQ-033 Load IR: from RTI apply TMS 1,1,0,0, shift TDI 0,0 with TMS=0 then 1 on the last bit, then TMS 1 -> in UPD_IR the next edge sets inst=00; TDO during the two SH_IR cycles reads 1 then 0.
REQ-034 With inst=00, DR scan: TMS 1,0,0 then three SH_DR cycles, EX1, UPD:
- clockdr_bs=1 for 4 cycles (CAP_DR plus 3× SH_DR), shiftdr_bs=1 for 3 cycles, updatedr_bs=1 for exactly 1 cycle;
- all _is strobes stay 0;
- TDO equals TDO_BSR during SH_DR.
REQ-035 With inst=10, the same DR scan drives only the _is strobes, and TDO equals TDO_ISR.
REQ-036 With inst=01, shift TDI pattern 1,0,1 through SH_DR -> TDO reads 0,1,0 (one-cycle delay) and no strobes are asserted.
REQ-037 Mid-SH_DR with inst=10: first go through PAU_DR and back and check that the bypass/ir state is held; then assert TRST -> next cycle tap_state=F, inst=01, and no updatedr_is pulse ever occurs.
